// File: rtl/serial_sub32_if.sv
// Handshake and operand/result bundle for the 4-bit-slice serial subtractor.
interface serial_sub32_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        bi;
  logic        busy;
  logic        done;
  logic [31:0] d;
  logic        bo;
  logic        z;
  logic        n;
  logic        v;

  modport master (output start, a, b, bi, input busy, done, d, bo, z, n, v);
  modport slave  (input start, a, b, bi, output busy, done, d, bo, z, n, v);
endinterface

// File: rtl/serial_sub32.sv
// 32-bit subtractor d = a - b - bi, computed one 4-bit slice per clock, LSB slice first,
// with the borrow rippling through a register between slices.
module serial_sub32_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         bin,
  output logic [W-1:0] diff,
  output logic         bout
);
  logic [W:0] r;
  // Bit W of the (W+1)-bit difference is set exactly when the slice underflows.
  assign r    = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bin};
  assign diff = r[W-1:0];
  assign bout = r[W];
endmodule

module serial_sub32 (
  input  logic           clk,
  input  logic           reset_n,
  serial_sub32_if.slave  bus
);
  localparam int WIDTH  = 32;
  localparam int SLICE  = 4;
  localparam int NSLICE = WIDTH / SLICE;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nx;
  logic [2:0]         cnt;
  logic [WIDTH-1:0]   a_r, b_r, d_r;
  logic               brw;
  logic               bo_r, z_r, n_r, v_r;
  logic               load, last, busy, done;
  logic [SLICE-1:0]   a_sl, b_sl, diff_sl;
  logic               bout_sl;
  logic [WIDTH-1:0]   d_full;

  assign a_sl = a_r[{cnt, 2'b00} +: SLICE];
  assign b_sl = b_r[{cnt, 2'b00} +: SLICE];

  serial_sub32_slice #(.W(SLICE)) u_slice (
    .x    (a_sl),
    .y    (b_sl),
    .bin  (brw),
    .diff (diff_sl),
    .bout (bout_sl)
  );

  assign last   = (state == RUN) && (cnt == 3'(NSLICE - 1));
  // Only meaningful on the last slice, when the lower 28 bits are already in d_r.
  assign d_full = {diff_sl, d_r[WIDTH-SLICE-1:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load     = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == 3'(NSLICE - 1)) state_nx = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (bus.start) begin
          load     = 1'b1;
          state_nx = RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      a_r  <= '0;
      b_r  <= '0;
      brw  <= 1'b0;
      d_r  <= '0;
      bo_r <= 1'b0;
      z_r  <= 1'b0;
      n_r  <= 1'b0;
      v_r  <= 1'b0;
    end else if (load) begin
      a_r <= bus.a;
      b_r <= bus.b;
      brw <= bus.bi;
      cnt <= '0;
    end else if (state == RUN) begin
      d_r[{cnt, 2'b00} +: SLICE] <= diff_sl;
      brw <= bout_sl;
      cnt <= cnt + 3'd1;
      if (last) begin
        bo_r <= bout_sl;
        z_r  <= (d_full == '0);
        n_r  <= d_full[WIDTH-1];
        v_r  <= (a_r[WIDTH-1] != b_r[WIDTH-1]) && (d_full[WIDTH-1] != a_r[WIDTH-1]);
      end
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.d    = d_r;
  assign bus.bo   = bo_r;
  assign bus.z    = z_r;
  assign bus.n    = n_r;
  assign bus.v    = v_r;
endmodule
